// File: rtl/dmem_dbg.sv
// dmem_dbg: byte-addressed little-endian data memory for the core's MEM stage,
// with a handshaked debug read port and a store-trace output.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   addr/wdata/we/re    CPU load/store request (byte address, store data, enables)
//   size/uns            access size (00 B, 01 H, 10 W, 11 illegal); zero-extend loads
//   rdata               registered load data
//   misalign            one-cycle pulse on illegal size or misaligned access
//   dbg_req/dbg_addr    debug word read request (byte address, any alignment)
//   dbg_ready           debug port idle, request accepted
//   dbg_valid/dbg_rdata debug read response, held until dbg_ack
//   dbg_ack             consumer takes the debug response
//   st_valid/st_addr/st_data/st_size  one-cycle trace of each committed store
module dmem_dbg #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [31:0]       rdata,
    output logic              misalign,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ready,
    output logic              dbg_valid,
    output logic [31:0]       dbg_rdata,
    input  logic              dbg_ack,
    output logic              st_valid,
    output logic [ADDR_W-1:0] st_addr,
    output logic [31:0]       st_data,
    output logic [1:0]        st_size
);

    localparam int unsigned AW = $clog2(MEM_SIZE);
    // One extra bit so address + length never wraps in range checks.
    localparam int unsigned EW = ADDR_W + 1;
    localparam logic [EW-1:0] MEM_END = EW'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP
    } dbg_state_t;

    logic [7:0] mem [MEM_SIZE];

    dbg_state_t        state, state_n;
    logic [ADDR_W-1:0] dbg_addr_q;

    logic [2:0]    nbytes_c;
    logic          legal_c;
    logic          in_range_c;
    logic          access_c;
    logic          wr_en_c;
    logic [EW-1:0] last_c;
    logic [AW-1:0] base_c;
    logic [31:0]   st_mask_c;
    logic [7:0]    lane_c [4];
    logic [31:0]   load_c;
    logic [EW-1:0] dbg_ba_c [4];
    logic [31:0]   dbg_word_c;

    // CPU access decode: size, alignment and range.
    always_comb begin
        nbytes_c  = 3'd4;
        legal_c   = 1'b1;
        st_mask_c = 32'hFFFF_FFFF;
        case (size)
            2'b00: begin
                nbytes_c  = 3'd1;
                st_mask_c = 32'h0000_00FF;
            end
            2'b01: begin
                nbytes_c  = 3'd2;
                st_mask_c = 32'h0000_FFFF;
                legal_c   = ~addr[0];
            end
            2'b10:   legal_c = (addr[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
        last_c     = EW'(addr) + EW'(nbytes_c) - EW'(1);
        in_range_c = (last_c < MEM_END);
        access_c   = we | re;
        wr_en_c    = we & legal_c & in_range_c;
        base_c     = addr[AW-1:0];
    end

    // Pre-write byte lanes at the CPU address; only consulted when in range.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_c[i] = mem[base_c + AW'(i)];
        end
    end

    // Load data with sign/zero extension.
    always_comb begin
        case (size)
            2'b00:   load_c = uns ? {24'h0, lane_c[0]} : {{24{lane_c[0][7]}}, lane_c[0]};
            2'b01:   load_c = uns ? {16'h0, lane_c[1], lane_c[0]}
                                  : {{16{lane_c[1][7]}}, lane_c[1], lane_c[0]};
            default: load_c = {lane_c[3], lane_c[2], lane_c[1], lane_c[0]};
        endcase
    end

    // Debug word, byte-wise so any alignment works; bytes past the end read 0.
    always_comb begin
        dbg_word_c = 32'h0;
        for (int i = 0; i < 4; i++) begin
            dbg_ba_c[i] = EW'(dbg_addr_q) + EW'(i);
            if (dbg_ba_c[i] < MEM_END) begin
                dbg_word_c[8*i +: 8] = mem[dbg_ba_c[i][AW-1:0]];
            end
        end
    end

    // Storage array, never reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(nbytes_c)) begin
                    mem[base_c + AW'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Debug FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Debug FSM next state; the CPU port stalls the READ state.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (dbg_req)   state_n = S_READ;
            S_READ:  if (!access_c) state_n = S_RESP;
            S_RESP:  if (dbg_ack)   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Registered outputs for both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata      <= 32'h0;
            misalign   <= 1'b0;
            st_valid   <= 1'b0;
            st_addr    <= '0;
            st_data    <= 32'h0;
            st_size    <= 2'b00;
            dbg_ready  <= 1'b1;
            dbg_valid  <= 1'b0;
            dbg_rdata  <= 32'h0;
            dbg_addr_q <= '0;
        end else begin
            misalign <= access_c & ~legal_c;
            if (access_c && !legal_c) begin
                rdata <= 32'h0;
            end else if (re) begin
                rdata <= in_range_c ? load_c : 32'h0;
            end

            st_valid <= wr_en_c;
            if (wr_en_c) begin
                st_addr <= addr;
                st_data <= wdata & st_mask_c;
                st_size <= size;
            end

            dbg_ready <= (state_n == S_IDLE);
            dbg_valid <= (state_n == S_RESP);
            if (state == S_IDLE && dbg_req) begin
                dbg_addr_q <= dbg_addr;
            end
            if (state == S_READ && !access_c) begin
                dbg_rdata <= dbg_word_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_dbg.sv
// Self-checking bench for dmem_dbg: directed cases plus random CPU traffic
// and debug reads against a byte-array reference model.
module tb_dmem_dbg;

    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned ADDR_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              we, re, uns;
    logic [1:0]        size;
    logic [31:0]       rdata;
    logic              misalign;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ready, dbg_valid;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;

    dmem_dbg #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .size(size), .uns(uns), .rdata(rdata), .misalign(misalign),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
        .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [MEM_SIZE];
    logic [31:0] exp_rdata;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_byte(input longint a);
        return (a < longint'(MEM_SIZE)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic logic [31:0] dbg_exp(input logic [31:0] a);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < 4; k++) v |= 32'(ref_byte(longint'(a) + longint'(k))) << (8 * k);
        return v;
    endfunction

    // One CPU cycle: predict from the model, drive, and check after the edge.
    task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
        int          nb;
        logic        legal, inr, exp_mis, exp_st;
        logic [31:0] v, mask;
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        legal   = (sz != 2'd3) && !(sz == 2'd1 && a[0]) && !(sz == 2'd2 && a[1:0] != 2'b00);
        inr     = (longint'(a) + longint'(nb)) <= longint'(MEM_SIZE);
        mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        exp_mis = (w | r) && !legal;
        exp_st  = w && legal && inr;
        if (exp_mis) begin
            exp_rdata = 32'h0;
        end else if (r) begin
            if (!inr) begin
                exp_rdata = 32'h0;
            end else begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v |= 32'(ref_mem[int'(a) + k]) << (8 * k);
                if (!u && nb < 4 && v[8*nb-1]) v |= ~mask;
                exp_rdata = v;
            end
        end
        if (exp_st) for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        we = w; re = r; size = sz; uns = u; addr = a; wdata = d;
        @(negedge clk);
        chk("rdata", rdata, exp_rdata);
        chk("misalign", 32'(misalign), 32'(exp_mis));
        chk("st_valid", 32'(st_valid), 32'(exp_st));
        if (exp_st) begin
            chk("st_addr", st_addr, a);
            chk("st_data", st_data, d & mask);
            chk("st_size", 32'(st_size), 32'(sz));
        end
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0;
        @(negedge clk);
        chk("idle_rdata", rdata, exp_rdata);
        chk("idle_misalign", 32'(misalign), 32'h0);
        chk("idle_st_valid", 32'(st_valid), 32'h0);
    endtask

    // Full debug transaction with the CPU port idle.
    task automatic dbg_read(input logic [31:0] a, input int exp_lat, input int ack_dly);
        logic [31:0] ev;
        int          lat;
        ev = dbg_exp(a);
        chk("dbg_ready_idle", 32'(dbg_ready), 32'h1);
        dbg_addr = a; dbg_req = 1'b1;
        idle();
        dbg_req = 1'b0;
        chk("dbg_ready_busy", 32'(dbg_ready), 32'h0);
        lat = 1;
        while (!dbg_valid && lat < 20) begin
            idle();
            lat++;
        end
        chk("dbg_valid", 32'(dbg_valid), 32'h1);
        if (exp_lat > 0) chk("dbg_latency", 32'(lat), 32'(exp_lat));
        chk("dbg_rdata", dbg_rdata, ev);
        repeat (ack_dly) begin
            idle();
            chk("dbg_hold_valid", 32'(dbg_valid), 32'h1);
            chk("dbg_hold_rdata", dbg_rdata, ev);
        end
        dbg_ack = 1'b1;
        idle();
        dbg_ack = 1'b0;
        chk("dbg_valid_drop", 32'(dbg_valid), 32'h0);
        chk("dbg_ready_back", 32'(dbg_ready), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; exp_rdata = 32'h0;
        rst = 1'b0; we = 1'b0; re = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0; dbg_req = 1'b0; dbg_addr = '0; dbg_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_dbg_ready", 32'(dbg_ready), 32'h1);
        chk("rst_dbg_valid", 32'(dbg_valid), 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_st_valid", 32'(st_valid), 32'h0);
        chk("rst_st_data", st_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Give every byte a known value.
        for (int i = 0; i < int'(MEM_SIZE) / 4; i++) op(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * i), $urandom);

        // Word store, trace, and debug readback at minimum latency.
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'd4, 32'h0F0F_0F0D);
        chk("sw_st_data", st_data, 32'h0F0F_0F0D);
        dbg_read(32'd4, 2, 0);

        // Byte/half stores with sign and zero extension.
        op(1'b1, 1'b0, 2'd0, 1'b0, 32'd22, 32'h0000_00C0);
        op(1'b0, 1'b1, 2'd0, 1'b0, 32'd22, 32'h0);
        chk("lb_sext", rdata, 32'hFFFF_FFC0);
        op(1'b0, 1'b1, 2'd0, 1'b1, 32'd22, 32'h0);
        chk("lbu_zext", rdata, 32'h0000_00C0);
        op(1'b1, 1'b0, 2'd1, 1'b0, 32'd16, 32'hFFFF_0011);
        chk("sh_st_data", st_data, 32'h0000_0011);
        op(1'b0, 1'b1, 2'd1, 1'b0, 32'd16, 32'h0);
        chk("lh", rdata, 32'h0000_0011);

        // Misaligned and illegal-size accesses leave memory untouched.
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'd6, 32'hDEAD_BEEF);
        idle();
        op(1'b1, 1'b0, 2'd1, 1'b0, 32'd17, 32'hDEAD_BEEF);
        idle();
        op(1'b0, 1'b1, 2'd3, 1'b0, 32'd0, 32'h0);
        idle();
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd4, 32'h0);
        chk("sw4_intact", rdata, 32'h0F0F_0F0D);

        // Debug read stalled by three cycles of CPU loads.
        dbg_addr = 32'd4; dbg_req = 1'b1;
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'h0);
        dbg_req = 1'b0;
        chk("stall_valid0", 32'(dbg_valid), 32'h0);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd12, 32'h0);
        chk("stall_valid1", 32'(dbg_valid), 32'h0);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd16, 32'h0);
        chk("stall_valid2", 32'(dbg_valid), 32'h0);
        idle();
        chk("stall_release", 32'(dbg_valid), 32'h1);
        chk("stall_rdata", dbg_rdata, 32'h0F0F_0F0D);
        repeat (5) begin
            idle();
            chk("stall_hold", dbg_rdata, 32'h0F0F_0F0D);
        end
        dbg_ack = 1'b1;
        idle();
        dbg_ack = 1'b0;
        chk("stall_valid_drop", 32'(dbg_valid), 32'h0);

        // Read-before-write on same-cycle store and load.
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h1111_1111);
        op(1'b1, 1'b1, 2'd2, 1'b0, 32'd8, 32'h2222_2222);
        chk("rbw_old", rdata, 32'h1111_1111);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'h0);
        chk("rbw_new", rdata, 32'h2222_2222);

        // Reset while a debug response is pending.
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'd100, 32'hA5A5_5A5A);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd100, 32'h0);
        idle();
        dbg_addr = 32'd100; dbg_req = 1'b1;
        idle();
        dbg_req = 1'b0;
        idle();
        chk("pre_rst_valid", 32'(dbg_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dbg_valid), 32'h0);
        chk("mid_rst_ready", 32'(dbg_ready), 32'h1);
        chk("mid_rst_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dbg_read(32'd100, 2, 1);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'd100, 32'h0);
        chk("rst_preserved", rdata, 32'hA5A5_5A5A);

        // Out-of-range accesses near the top of memory.
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'(MEM_SIZE), 32'h0);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'(MEM_SIZE - 4), 32'h0);
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'(MEM_SIZE + 8), 32'h1234_5678);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'(MEM_SIZE - 2), 32'h0);
        dbg_read(32'(MEM_SIZE - 2), 2, 0);

        // Random CPU traffic with interleaved debug reads.
        for (int it = 0; it < 600; it++) begin
            int unsigned pick;
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                dbg_read(32'($urandom_range(0, MEM_SIZE + 2)), 2, int'($urandom_range(0, 3)));
            end else if (pick == 1) begin
                idle();
            end else begin
                logic [1:0]  sz;
                logic [31:0] a;
                int unsigned mode;
                int          nb;
                sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                mode = $urandom_range(0, 9);
                if (mode < 7)       a = 32'($urandom_range(0, MEM_SIZE - 1)) & ~(32'(nb) - 32'd1);
                else if (mode < 9)  a = 32'($urandom_range(0, MEM_SIZE + 8));
                else                a = $urandom;
                op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), a, $urandom);
            end
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
